ip_reg_cdc_bridge: RTL and testbench
====================================

IP_REG_CDC_BRIDGE -- requirements
Module: ip_reg_cdc_bridge

Interface
REQ-001 Parameters: ADDR_W, 32, address width; DATA_W, 32, data width (multiple of 8); TMO_B, 1024, clockB cycles before B-side access times out; TMO_A, 4096, clockA cycles before A-side watchdog fires; ERR_DATA, 32'hDEAD_BEEF, read data returned on any error.
REQ-002 clockB  in  1  B-domain clock.
REQ-003 resetB  in  1  B-domain reset, asynchronous, active-low.
REQ-004 clockA  in  1  A-domain clock.
REQ-005 resetA  in  1  A-domain reset, asynchronous, active-low.
REQ-006 registerSelectA  in  1  request, held high until registerAckA.
REQ-007 registerReadA  in  1  1 = read, 0 = write.
REQ-008 registerAddressA / registerWriteDataA / registerByteEnA  in  ADDR_W / DATA_W / DATA_W/8  request fields, stable while select is high.
REQ-009 registerAckA / registerErrorA  out  1 / 1  one-cycle completion pulse; error qualifier.
REQ-010 registerReadDataA  out  DATA_W  read data, valid with registerAckA.
REQ-011 registerSelectB / registerReadB / registerAddressB / registerWriteDataB / registerByteEnB  out  1 / 1 / ADDR_W / DATA_W / DATA_W/8  B-side access.
REQ-012 registerAckB / registerErrorB / registerReadDataB  in  1 / 1 / DATA_W  B-side completion.

Function
REQ-013 Crossing uses a two-phase toggle handshake: reqToggleA (A to B) and ackToggleB (B to A), each synchronised through a 2-flop synchroniser; request/response fields cross as held buses, never synchronised bitwise.
REQ-014 A FSM IDLE->WAIT on a registerSelectA rising edge (select high, registered select low) in IDLE: capture the request fields into holding registers, flip reqToggleA, clear the watchdog.
REQ-015 WAIT->IDLE when the synced ackToggle equals reqToggleA: registerAckA pulses for 1 cycle; registerErrorA and registerReadDataA are loaded from the B holding registers.
REQ-016 WAIT->IDLE when the watchdog reaches TMO_A: registerAckA = 1, registerErrorA = 1, registerReadDataA = ERR_DATA; a later matching B ack is discarded.
REQ-017 Select dropped in WAIT: the transaction continues; on completion no registerAckA pulse is issued; the FSM returns to IDLE.
REQ-018 B FSM states: RESYNC, IDLE, ACCESS.
REQ-019 RESYNC: held for 3 clockB cycles after resetB deasserts; then ackToggleB <= synced reqToggle and the FSM goes to IDLE; no access is issued.
REQ-020 IDLE->ACCESS when synced reqToggle != ackToggleB: load the B request outputs from the A holding registers; registerSelectB = 1 on the next cycle; clear timeout counter.
REQ-021 ACCESS->IDLE on registerAckB: registerSelectB = 0 the same edge; capture registerErrorB and registerReadDataB; flip ackToggleB.
REQ-022 ACCESS->IDLE when the timeout counter reaches TMO_B with no ack: capture error = 1 and data = ERR_DATA; flip ackToggleB.
REQ-023 An ack arriving on the TMO_B cycle itself is treated as a normal ack.
REQ-024 Write requests return read data = the captured B value (don't-care to A); registerErrorA is valid for both request types.
REQ-025 Counters are $clog2(TMO)+1 bits and saturate; they never wrap.
REQ-026 Minimum latency: 2 sync + 1 B load + 1 B ack + 2 sync + 1 A output, so registerAckA comes 7 clockA-equivalent edges after a select edge when the B ack is immediate.

Reset
REQ-027 resetA: A FSM = IDLE, reqToggleA = 0, registerAckA = 0, registerErrorA = 0, registerReadDataA = 0.
REQ-028 resetB: B FSM = RESYNC, ackToggleB = 0, registerSelectB = 0, other B outputs = 0.
REQ-029 resetB during ACCESS aborts the access silently; A recovers through the REQ-016 watchdog.

Structure
REQ-030 A shared package holds the A and B state encodings, the default ERR_DATA, and the RESYNC length constant.
REQ-031 The 2-flop synchroniser is the existing 1-bit IP_SyncFlop, instantiated twice; no other sub-module is used.

Verification
REQ-032 Read with A = 100 MHz, B = 33 MHz, registerAckB 2 cycles after select, data 32'h1234_5678 -> one registerAckA pulse, error 0, data 32'h1234_5678.
REQ-033 Write with byte enable 4'b0101 -> registerByteEnB = 4'b0101 and registerWriteDataB matches for the whole select; exactly one registerSelectB assertion.
REQ-034 No registerAckB -> registerSelectB drops after TMO_B cycles; registerAckA with error 1, data 32'hDEAD_BEEF.
REQ-035 resetB pulsed mid-ACCESS -> A gets an error ack after TMO_A cycles; the next request completes normally; no spurious B access.
REQ-036 Select dropped in WAIT -> no registerAckA pulse; 50 back-to-back requests afterwards all complete in order.

Source files
------------

// File: rtl/ip_reg_cdc_bridge_pkg.sv
// Shared types and constants for the A/B register bridge.
// Holds FSM encodings, default error data and resync length.
package ip_reg_cdc_bridge_pkg;

   typedef enum logic {
      A_IDLE = 1'b0,
      A_WAIT = 1'b1
   } a_state_e;

   typedef enum logic [1:0] {
      B_RESYNC = 2'd0,
      B_IDLE   = 2'd1,
      B_ACCESS = 2'd2
   } b_state_e;

   localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
   localparam int          RESYNC_LEN   = 3;

endpackage

// File: rtl/IP_SyncFlop.sv
// Two-flop single-bit synchroniser.
// Output resets low with the destination domain.
module IP_SyncFlop (
   input  logic clk_i,
   input  logic rstB_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;

   always_ff @(posedge clk_i or negedge rstB_i) begin
      if (!rstB_i) begin
         meta_q <= 1'b0;
         q_o    <= 1'b0;
      end else begin
         meta_q <= d_i;
         q_o    <= meta_q;
      end
   end

endmodule

// File: rtl/ip_reg_cdc_bridge.sv
// Register access bridge from clockA master to clockB slave.
// Two-phase toggle handshake; request/response fields held.
module ip_reg_cdc_bridge
   import ip_reg_cdc_bridge_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                TMO_B    = 1024,
   parameter int                TMO_A    = 4096,
   parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
   input  logic                clockB,
   input  logic                resetB,
   input  logic                clockA,
   input  logic                resetA,
   input  logic                registerSelectA,
   input  logic                registerReadA,
   input  logic [ADDR_W-1:0]   registerAddressA,
   input  logic [DATA_W-1:0]   registerWriteDataA,
   input  logic [DATA_W/8-1:0] registerByteEnA,
   output logic                registerAckA,
   output logic                registerErrorA,
   output logic [DATA_W-1:0]   registerReadDataA,
   output logic                registerSelectB,
   output logic                registerReadB,
   output logic [ADDR_W-1:0]   registerAddressB,
   output logic [DATA_W-1:0]   registerWriteDataB,
   output logic [DATA_W/8-1:0] registerByteEnB,
   input  logic                registerAckB,
   input  logic                registerErrorB,
   input  logic [DATA_W-1:0]   registerReadDataB
);

   localparam int BE_W = DATA_W / 8;
   localparam int WA_W = $clog2(TMO_A) + 1;
   localparam int WB_W = $clog2(TMO_B) + 1;

   // ---------------- A domain ----------------
   a_state_e          stateA_q;
   logic              reqToggleA_q;
   logic              armed_q;
   logic              dropped_q;
   logic [WA_W-1:0]   wdog_q;
   logic [WA_W-1:0]   wdog_d;
   logic              readHold_q;
   logic [ADDR_W-1:0] addrHold_q;
   logic [DATA_W-1:0] wdataHold_q;
   logic [BE_W-1:0]   beHold_q;

   // ---------------- B domain ----------------
   b_state_e          stateB_q;
   logic [1:0]        rsCnt_q;
   logic              ackToggleB_q;
   logic              respValidB_q;
   logic              respErrB_q;
   logic [DATA_W-1:0] respDataB_q;
   logic [WB_W-1:0]   tmo_q;
   logic [WB_W-1:0]   tmo_d;

   logic ackSyncA;
   logic reqSyncB;
   logic hsIdleA;
   logic ackSeenA;
   logic wdogHitA;
   logic dropA;
   logic tmoHitB;

   IP_SyncFlop u_syncAck (
      .clk_i  (clockA),
      .rstB_i (resetA),
      .d_i    (ackToggleB_q),
      .q_o    (ackSyncA)
   );

   IP_SyncFlop u_syncReq (
      .clk_i  (clockB),
      .rstB_i (resetB),
      .d_i    (reqToggleA_q),
      .q_o    (reqSyncB)
   );

   assign hsIdleA  = (ackSyncA == reqToggleA_q);
   // A toggle match from a B-side resync carries no response
   assign ackSeenA = hsIdleA && respValidB_q;
   assign wdogHitA = (wdog_q >= WA_W'(TMO_A - 1));
   assign dropA    = dropped_q || !registerSelectA;
   assign wdog_d   = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;

   always_ff @(posedge clockA or negedge resetA) begin
      if (!resetA) begin
         stateA_q          <= A_IDLE;
         reqToggleA_q      <= 1'b0;
         armed_q           <= 1'b0;
         dropped_q         <= 1'b0;
         wdog_q            <= '0;
         readHold_q        <= 1'b0;
         addrHold_q        <= '0;
         wdataHold_q       <= '0;
         beHold_q          <= '0;
         registerAckA      <= 1'b0;
         registerErrorA    <= 1'b0;
         registerReadDataA <= '0;
      end else begin
         registerAckA <= 1'b0;
         if (!registerSelectA) armed_q <= 1'b0;
         unique case (stateA_q)
            A_IDLE: begin
               // wait out any stale ack before launching
               if (registerSelectA && !armed_q && hsIdleA) begin
                  readHold_q   <= registerReadA;
                  addrHold_q   <= registerAddressA;
                  wdataHold_q  <= registerWriteDataA;
                  beHold_q     <= registerByteEnA;
                  reqToggleA_q <= ~reqToggleA_q;
                  wdog_q       <= '0;
                  armed_q      <= 1'b1;
                  dropped_q    <= 1'b0;
                  stateA_q     <= A_WAIT;
               end
            end
            A_WAIT: begin
               if (!registerSelectA) dropped_q <= 1'b1;
               if (ackSeenA || wdogHitA) begin
                  registerAckA      <= !dropA;
                  registerErrorA    <= ackSeenA ? respErrB_q : 1'b1;
                  registerReadDataA <= ackSeenA ? respDataB_q : ERR_DATA;
                  stateA_q          <= A_IDLE;
               end else begin
                  wdog_q <= wdog_d;
               end
            end
            default: stateA_q <= A_IDLE;
         endcase
      end
   end

   assign tmoHitB = (tmo_q >= WB_W'(TMO_B - 1));
   assign tmo_d   = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;

   always_ff @(posedge clockB or negedge resetB) begin
      if (!resetB) begin
         stateB_q           <= B_RESYNC;
         rsCnt_q            <= '0;
         ackToggleB_q       <= 1'b0;
         respValidB_q       <= 1'b0;
         respErrB_q         <= 1'b0;
         respDataB_q        <= '0;
         tmo_q              <= '0;
         registerSelectB    <= 1'b0;
         registerReadB      <= 1'b0;
         registerAddressB   <= '0;
         registerWriteDataB <= '0;
         registerByteEnB    <= '0;
      end else begin
         unique case (stateB_q)
            B_RESYNC: begin
               // adopt the pending toggle so nothing is replayed
               if (rsCnt_q == 2'(RESYNC_LEN - 1)) begin
                  ackToggleB_q <= reqSyncB;
                  stateB_q     <= B_IDLE;
               end else begin
                  rsCnt_q <= rsCnt_q + 2'd1;
               end
            end
            B_IDLE: begin
               if (reqSyncB != ackToggleB_q) begin
                  registerSelectB    <= 1'b1;
                  registerReadB      <= readHold_q;
                  registerAddressB   <= addrHold_q;
                  registerWriteDataB <= wdataHold_q;
                  registerByteEnB    <= beHold_q;
                  tmo_q              <= '0;
                  stateB_q           <= B_ACCESS;
               end
            end
            B_ACCESS: begin
               if (registerAckB) begin
                  registerSelectB <= 1'b0;
                  respErrB_q      <= registerErrorB;
                  respDataB_q     <= registerReadDataB;
                  respValidB_q    <= 1'b1;
                  ackToggleB_q    <= ~ackToggleB_q;
                  stateB_q        <= B_IDLE;
               end else if (tmoHitB) begin
                  registerSelectB <= 1'b0;
                  respErrB_q      <= 1'b1;
                  respDataB_q     <= ERR_DATA;
                  respValidB_q    <= 1'b1;
                  ackToggleB_q    <= ~ackToggleB_q;
                  stateB_q        <= B_IDLE;
               end else begin
                  tmo_q <= tmo_d;
               end
            end
            default: stateB_q <= B_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ip_reg_cdc_bridge.sv
// Directed bench for ip_reg_cdc_bridge.
// Table of transactions plus reset/drop/back-to-back sequences.
module tb_ip_reg_cdc_bridge;

   localparam int TMO_B = 16;
   localparam int TMO_A = 128;

   logic        clockA = 1'b0;
   logic        clockB = 1'b0;
   logic        resetA;
   logic        resetB;
   logic        registerSelectA;
   logic        registerReadA;
   logic [31:0] registerAddressA;
   logic [31:0] registerWriteDataA;
   logic [3:0]  registerByteEnA;
   logic        registerAckA;
   logic        registerErrorA;
   logic [31:0] registerReadDataA;
   logic        registerSelectB;
   logic        registerReadB;
   logic [31:0] registerAddressB;
   logic [31:0] registerWriteDataB;
   logic [3:0]  registerByteEnB;
   logic        registerAckB;
   logic        registerErrorB;
   logic [31:0] registerReadDataB;

   ip_reg_cdc_bridge #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .TMO_B    (TMO_B),
      .TMO_A    (TMO_A),
      .ERR_DATA (32'hDEAD_BEEF)
   ) dut (
      .clockB             (clockB),
      .resetB             (resetB),
      .clockA             (clockA),
      .resetA             (resetA),
      .registerSelectA    (registerSelectA),
      .registerReadA      (registerReadA),
      .registerAddressA   (registerAddressA),
      .registerWriteDataA (registerWriteDataA),
      .registerByteEnA    (registerByteEnA),
      .registerAckA       (registerAckA),
      .registerErrorA     (registerErrorA),
      .registerReadDataA  (registerReadDataA),
      .registerSelectB    (registerSelectB),
      .registerReadB      (registerReadB),
      .registerAddressB   (registerAddressB),
      .registerWriteDataB (registerWriteDataB),
      .registerByteEnB    (registerByteEnB),
      .registerAckB       (registerAckB),
      .registerErrorB     (registerErrorB),
      .registerReadDataB  (registerReadDataB)
   );

   always #5 clockA = ~clockA;
   always #15 clockB = ~clockB;

   int nChecks = 0;
   int nErrors = 0;
   int ackCount = 0;

   always @(negedge clockA) if (registerAckA) ackCount++;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // B-side responder
   int          ackDly = 0;
   logic        bErr = 1'b0;
   logic [31:0] bData = '0;
   int          bCnt = 0;
   int          bRise = 0;
   int          bLen = 0;
   logic        bStable = 1'b1;
   logic        bRd = 1'b0;
   logic [31:0] bAddr = '0;
   logic [31:0] bWd = '0;
   logic [3:0]  bBe = '0;

   initial begin
      registerAckB      = 1'b0;
      registerErrorB    = 1'b0;
      registerReadDataB = '0;
      forever begin
         @(posedge clockB); #1;
         registerAckB = 1'b0;
         if (registerSelectB) begin
            bCnt++;
            if (bCnt == 1) begin
               bRise++;
               bRd     = registerReadB;
               bAddr   = registerAddressB;
               bWd     = registerWriteDataB;
               bBe     = registerByteEnB;
               bStable = 1'b1;
            end else if (registerAddressB !== bAddr ||
                         registerWriteDataB !== bWd ||
                         registerByteEnB !== bBe ||
                         registerReadB !== bRd) begin
               bStable = 1'b0;
            end
            if (ackDly >= 0 && bCnt == ackDly + 1) begin
               registerAckB      = 1'b1;
               registerErrorB    = bErr;
               registerReadDataB = bData;
            end
         end else begin
            if (bCnt != 0) bLen = bCnt;
            bCnt = 0;
         end
      end
   end

   task automatic aReq(input logic rd, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [3:0] be,
                       output logic got, output logic err,
                       output logic [31:0] data, output int lat);
      @(posedge clockA); #1;
      registerReadA      = rd;
      registerAddressA   = ad;
      registerWriteDataA = wd;
      registerByteEnA    = be;
      registerSelectA    = 1'b1;
      got  = 1'b0;
      err  = 1'b0;
      data = '0;
      lat  = 0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(posedge clockA); #1;
         lat++;
         if (registerAckA) begin
            got  = 1'b1;
            err  = registerErrorA;
            data = registerReadDataA;
         end
      end
      registerSelectA = 1'b0;
      @(posedge clockA); #1;
   endtask

   typedef struct {
      logic        rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          dly;
      logic        bErr;
      logic [31:0] bData;
      logic        expErr;
      logic [31:0] expData;
      int          expLen;
   } vec_t;

   vec_t vecs[7];

   logic        got;
   logic        err;
   logic [31:0] data;
   int          lat;

   initial begin
      #5000000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation hung");
   end

   initial begin
      vecs[0] = '{1'b1, 32'h0000_0010, 32'h0, 4'hF, 2, 1'b0,
                  32'h1234_5678, 1'b0, 32'h1234_5678, 3};
      vecs[1] = '{1'b0, 32'h0000_0024, 32'hA5A5_5A5A, 4'b0101, 2, 1'b0,
                  32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 3};
      vecs[2] = '{1'b1, 32'h0000_0100, 32'h0, 4'hF, 0, 1'b1,
                  32'h5555_AAAA, 1'b1, 32'h5555_AAAA, 1};
      vecs[3] = '{1'b1, 32'hFFFF_FFFC, 32'h0, 4'hF, 15, 1'b0,
                  32'hCAFE_0001, 1'b0, 32'hCAFE_0001, 16};
      vecs[4] = '{1'b1, 32'h0000_0200, 32'h0, 4'hF, -1, 1'b0,
                  32'h1111_1111, 1'b1, 32'hDEAD_BEEF, 16};
      vecs[5] = '{1'b0, 32'h0000_0300, 32'h0123_4567, 4'b1000, 5, 1'b1,
                  32'h0, 1'b1, 32'h0, 6};
      vecs[6] = '{1'b1, 32'h0000_0400, 32'h0, 4'b0011, 1, 1'b0,
                  32'h8000_0001, 1'b0, 32'h8000_0001, 2};

      resetA             = 1'b0;
      resetB             = 1'b0;
      registerSelectA    = 1'b0;
      registerReadA      = 1'b0;
      registerAddressA   = '0;
      registerWriteDataA = '0;
      registerByteEnA    = '0;
      repeat (5) @(posedge clockA); #1;
      chk("rst_ackA", 32'(registerAckA), 0);
      chk("rst_errA", 32'(registerErrorA), 0);
      chk("rst_rdataA", registerReadDataA, 0);
      chk("rst_selB", 32'(registerSelectB), 0);
      chk("rst_addrB", registerAddressB, 0);
      chk("rst_wdataB", registerWriteDataB, 0);
      chk("rst_beB", 32'(registerByteEnB), 0);
      resetA = 1'b1;
      resetB = 1'b1;
      repeat (20) @(posedge clockA); #1;
      chk("resync_no_access", 32'(bRise), 0);
      chk("resync_no_ack", 32'(ackCount), 0);

      for (int v = 0; v < 7; v++) begin
         ackDly   = vecs[v].dly;
         bErr     = vecs[v].bErr;
         bData    = vecs[v].bData;
         bRise    = 0;
         bLen     = 0;
         ackCount = 0;
         aReq(vecs[v].rd, vecs[v].addr, vecs[v].wdata, vecs[v].be,
              got, err, data, lat);
         repeat (3) @(posedge clockB); #1;
         chk($sformatf("v%0d_ack", v), 32'(got), 1);
         chk($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].expErr));
         chk($sformatf("v%0d_data", v), data, vecs[v].expData);
         chk($sformatf("v%0d_pulses", v), 32'(ackCount), 1);
         chk($sformatf("v%0d_bsel_once", v), 32'(bRise), 1);
         chk($sformatf("v%0d_bsel_len", v), 32'(bLen),
             32'(vecs[v].expLen));
         chk($sformatf("v%0d_baddr", v), bAddr, vecs[v].addr);
         chk($sformatf("v%0d_bread", v), 32'(bRd), 32'(vecs[v].rd));
         chk($sformatf("v%0d_bbe", v), 32'(bBe), 32'(vecs[v].be));
         chk($sformatf("v%0d_bwdata", v), bWd, vecs[v].wdata);
         chk($sformatf("v%0d_bstable", v), 32'(bStable), 1);
      end

      // resetB pulsed while the B access is open
      ackDly   = -1;
      bRise    = 0;
      ackCount = 0;
      fork
         aReq(1'b1, 32'h0000_0500, 32'h0, 4'hF, got, err, data, lat);
         begin : rstb_pulse
            int w;
            w = 0;
            while (!registerSelectB && w < 200) begin
               @(posedge clockB); #1;
               w++;
            end
            @(posedge clockB); #1;
            resetB = 1'b0;
            @(posedge clockB); #1;
            resetB = 1'b1;
         end
      join
      repeat (6) @(posedge clockB); #1;
      chk("rstb_ack", 32'(got), 1);
      chk("rstb_err", 32'(err), 1);
      chk("rstb_data", data, 32'hDEAD_BEEF);
      chk("rstb_wdog_len", 32'(lat >= TMO_A), 1);
      chk("rstb_no_replay", 32'(bRise), 1);
      chk("rstb_selB_low", 32'(registerSelectB), 0);
      ackDly = 1;
      bErr   = 1'b0;
      bData  = 32'h7777_0001;
      aReq(1'b1, 32'h0000_0504, 32'h0, 4'hF, got, err, data, lat);
      chk("post_rstb_ack", 32'(got), 1);
      chk("post_rstb_err", 32'(err), 0);
      chk("post_rstb_data", data, 32'h7777_0001);
      chk("post_rstb_bsel", 32'(bRise), 2);

      // select dropped while waiting
      ackDly   = 2;
      bData    = 32'h3333_0000;
      bRise    = 0;
      bLen     = 0;
      ackCount = 0;
      @(posedge clockA); #1;
      registerReadA    = 1'b1;
      registerAddressA = 32'h0000_0600;
      registerSelectA  = 1'b1;
      repeat (3) @(posedge clockA); #1;
      registerSelectA = 1'b0;
      repeat (100) @(posedge clockA); #1;
      chk("drop_no_ack", 32'(ackCount), 0);
      chk("drop_b_done", 32'(bRise), 1);
      chk("drop_b_len", 32'(bLen), 3);

      bRise    = 0;
      ackCount = 0;
      for (int i = 0; i < 50; i++) begin
         ackDly = i % 3;
         bErr   = 1'b0;
         bData  = 32'h1000_0000 + 32'(i);
         aReq(1'b1, 32'(i * 4), 32'h0, 4'hF, got, err, data, lat);
         chk($sformatf("b2b%0d_data", i), data, 32'h1000_0000 + 32'(i));
      end
      repeat (3) @(posedge clockB); #1;
      chk("b2b_ack_count", 32'(ackCount), 50);
      chk("b2b_bsel_count", 32'(bRise), 50);

      $display("Simulation finished: %0d checks, %0d errors",
               nChecks, nErrors);
      $finish;
   end

endmodule
